rv_write_stage: RTL
===================

# rv_write_stage

Registered, handshaked writeback stage for the RV core, parametrised in XLEN (32/64). It accepts one retiring instruction per cycle from the memory stage, waits for split-transaction load data when required, then aligns and extends that data. It drives a single-cycle register-file write pulse and reports load bus errors, plus misaligned loads when that check is compiled in. It sits between the data-memory interface and the register file, replacing the purely combinational writeback path.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept an instruction this cycle.
- i_alu_result  in  XLEN  ALU result; for loads, the effective address.
- i_reg_write  in  1  instruction writes rd.
- i_rd  in  5  destination register.
- i_res_src  in  2  result select: 0 ALU, 1 MEMORY, 2 PC_P4, 3 reserved.
- i_pc_p4  in  XLEN-2  PC+4 bits [XLEN-1:2].
- i_funct3  in  3  load size and sign.
- i_mem_valid  in  1  load response valid.
- i_mem_data  in  XLEN  load response data, naturally aligned word or doubleword.
- i_mem_err  in  1  load bus error; qualified by i_mem_valid.
- o_data  out  XLEN  writeback data.
- o_rd  out  5  writeback register.
- o_reg_write  out  1  one-cycle register-file write strobe.
- o_fault  out  1  one-cycle fault pulse.
- o_fault_misalign  out  1  fault cause: 1 misaligned, 0 bus error; valid with o_fault.

## Operation
- FSM states: IDLE, WAIT_MEM, RET.
- o_ready is 1 in IDLE and RET and 0 in WAIT_MEM.
- An instruction is accepted on i_valid & o_ready. On acceptance the stage captures alu_result, rd, reg_write, res_src, pc_p4 and funct3.
- Accepted instruction with res_src=MEMORY goes to WAIT_MEM. Any other res_src goes to RET.
- In WAIT_MEM, i_mem_valid moves the FSM to RET and captures the aligned load data and the error flag. i_mem_valid is ignored in IDLE and RET.
- In RET, the stage drives:
  - o_reg_write = reg_write & (rd≠0) & ~fault;
  - o_fault = fault.
- From RET, the FSM returns to IDLE, or goes to WAIT_MEM/RET if a new instruction is accepted in the same cycle. This gives back-to-back throughput of one non-load per cycle.
- Result selection:
  - ALU: alu_result.
  - PC_P4: {pc_p4,2'b00}.
  - MEMORY: aligned load data.
  - Reserved value 3: 0.
- Load alignment:
  - Byte lane = addr[log2(XLEN/8)-1:0].
  - Halfword lane = addr[..:1].
  - Word lane = addr[..:2]; on XLEN=32 this is always the whole word.
- funct3 handling:
  - 000: sign-extend byte.
  - 001: sign-extend halfword.
  - 010: sign-extend word.
  - 100: zero-extend byte.
  - 101: zero-extend halfword.
  - 110 LWU and 011 LD: only when XLEN=64.
  - Any other funct3, and 110/011 when XLEN=32: data 0, no fault.
- Bus error (i_mem_err): o_fault=1, o_fault_misalign=0, no register write.
- o_data and o_rd hold their last values outside RET.

## Timing
- Reset values: FSM=IDLE, o_ready=1, o_reg_write=0, o_fault=0, o_fault_misalign=0, o_data=0, o_rd=0.
- Non-load latency: outputs are valid in the cycle after acceptance.
- Load latency: outputs are valid in the cycle after i_mem_valid. Zero-wait memory therefore costs 2 cycles per load.
- A reset asserted in WAIT_MEM drops the pending load. A late response arriving after reset is ignored, because the FSM is in IDLE.
- Simultaneous RET output and new acceptance: the current instruction retires and the new one is captured on the same edge.

## Configuration
- RV_WB_MISALIGN_TRAP_EN defined:
  - A load is misaligned when it is a halfword with addr[0]≠0, a word with addr[1:0]≠0, or a doubleword with addr[2:0]≠0.
  - A misaligned load goes directly to RET without waiting for memory: o_fault=1, o_fault_misalign=1, no write.
  - Memory must not issue a response for it.
- RV_WB_MISALIGN_TRAP_EN undefined:
  - No check is made; the low address bits below natural alignment are ignored.
  - o_fault_misalign is tied 0.

## Structure
- Package rv_wb_pkg holds:
  - result_src_e (ALU/MEMORY/PC_P4/RSVD);
  - load funct3 constants;
  - wb_state_e (IDLE/WAIT_MEM/RET).
- Sub-module rv_load_align: combinational lane select plus sign/zero extension, parametrised by XLEN, with inputs data, addr and funct3.

## Test plan
- XLEN=32, ALU result 0x1234_5678, rd=5, accepted in cycle 0 → cycle 1: o_reg_write=1, o_rd=5, o_data=0x1234_5678. Back-to-back second instruction retires in cycle 2.
- XLEN=32 LB, addr 0x...03, mem data 0x80AA_BBCC, response after 3 cycles → o_ready=0 while waiting; o_data=0xFFFF_FF80, o_reg_write one cycle after i_mem_valid.
- XLEN=64 LWU, addr 0x...04, data 0xDEAD_BEEF_0000_0001 → o_data=0x0000_0000_DEAD_BEEF. The same data with LW gives 0xFFFF_FFFF_DEAD_BEEF.
- Load with i_mem_err=1 → o_fault=1, o_fault_misalign=0, o_reg_write=0. Write to rd=0 → o_reg_write=0.
- With RV_WB_MISALIGN_TRAP_EN defined, LH at addr 0x...01 → RET the next cycle with o_fault=1 and o_fault_misalign=1, and the FSM never enters WAIT_MEM.
- Reset asserted in WAIT_MEM, then i_mem_valid arrives → no write, no fault, o_ready=1.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the RV writeback stage.
package rv_wb_pkg;

  typedef enum logic [1:0] {
    ALU    = 2'd0,
    MEMORY = 2'd1,
    PC_P4  = 2'd2,
    RSVD   = 2'd3
  } result_src_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    RET
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/rv_load_align.sv
// Load-data lane select and sign/zero extension for naturally aligned bus data.
module rv_load_align
  import rv_wb_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [OFFW-1:0] i_addr,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data_c
);

  logic [OFFW-1:0] off_h;
  logic [OFFW-1:0] off_w;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [31:0]     word_c;

  // Address bits below the access size are dropped before lane selection.
  always_comb begin
    off_h  = i_addr & ~OFFW'(1);
    off_w  = i_addr & ~OFFW'(3);
    byte_c = 8'(i_data >> {i_addr, 3'b000});
    half_c = 16'(i_data >> {off_h, 3'b000});
    word_c = 32'(i_data >> {off_w, 3'b000});
    o_data_c = '0;
    case (i_funct3)
      F3_LB:   o_data_c = XLEN'($signed(byte_c));
      F3_LH:   o_data_c = XLEN'($signed(half_c));
      F3_LW:   o_data_c = XLEN'($signed(word_c));
      F3_LBU:  o_data_c = XLEN'(byte_c);
      F3_LHU:  o_data_c = XLEN'(half_c);
      F3_LWU:  if (XLEN == 64) o_data_c = XLEN'(word_c);
      F3_LD:   if (XLEN == 64) o_data_c = i_data;
      default: o_data_c = '0;
    endcase
  end

endmodule

// File: rtl/rv_write_stage.sv
// Registered writeback stage: waits for split-transaction load data, aligns it and pulses the RF write.
// Optional misaligned-load trap compiled in with RV_WB_MISALIGN_TRAP_EN.
module rv_write_stage
  import rv_wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_reg_write,
  input  logic [4:0]      i_rd,
  input  logic [1:0]      i_res_src,
  input  logic [XLEN-3:0] i_pc_p4,
  input  logic [2:0]      i_funct3,
  input  logic            i_mem_valid,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_mem_err,
  output logic [XLEN-1:0] o_data,
  output logic [4:0]      o_rd,
  output logic            o_reg_write,
  output logic            o_fault,
  output logic            o_fault_misalign
);

  localparam int unsigned OFFW = $clog2(XLEN / 8);

  wb_state_e       state_q, state_d;
  logic            ready_q, ready_d;
  logic [OFFW-1:0] addr_q, addr_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            we_q, we_d;
  logic            fault_q, fault_d;
  logic            mis_q, mis_d;

  logic            accept_c;
  logic            misalign_c;
  logic [XLEN-1:0] sel_c;
  logic [XLEN-1:0] load_data_c;

  assign accept_c = i_valid & ready_q;

  rv_load_align #(.XLEN(XLEN)) u_align (
    .i_data   (i_mem_data),
    .i_addr   (addr_q),
    .i_funct3 (funct3_q),
    .o_data_c (load_data_c)
  );

`ifdef RV_WB_MISALIGN_TRAP_EN
  always_comb begin
    misalign_c = 1'b0;
    case (i_funct3)
      F3_LH, F3_LHU: misalign_c = i_alu_result[0];
      F3_LW:         misalign_c = |i_alu_result[1:0];
      F3_LWU:        misalign_c = (XLEN == 64) && (|i_alu_result[1:0]);
      F3_LD:         misalign_c = (XLEN == 64) && (|i_alu_result[2:0]);
      default:       misalign_c = 1'b0;
    endcase
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Non-load result; loads take their data from the aligner later.
  always_comb begin
    case (result_src_e'(i_res_src))
      ALU:     sel_c = i_alu_result;
      PC_P4:   sel_c = {i_pc_p4, 2'b00};
      default: sel_c = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    funct3_d    = funct3_q;
    data_d      = data_q;
    out_rd_d    = out_rd_q;
    we_d        = 1'b0;
    fault_d     = 1'b0;
    mis_d       = 1'b0;
    case (state_q)
      WAIT_MEM: begin
        if (i_mem_valid) begin
          state_d  = RET;
          out_rd_d = rd_q;
          fault_d  = i_mem_err;
          we_d     = reg_write_q & (rd_q != 5'd0) & ~i_mem_err;
          if (!i_mem_err) data_d = load_data_c;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept_c) begin
          addr_d      = i_alu_result[OFFW-1:0];
          rd_d        = i_rd;
          reg_write_d = i_reg_write;
          funct3_d    = i_funct3;
          if (result_src_e'(i_res_src) != MEMORY) begin
            state_d  = RET;
            data_d   = sel_c;
            out_rd_d = i_rd;
            we_d     = i_reg_write & (i_rd != 5'd0);
          end else if (misalign_c) begin
            state_d  = RET;
            out_rd_d = i_rd;
            fault_d  = 1'b1;
            mis_d    = 1'b1;
          end else begin
            state_d = WAIT_MEM;
          end
        end
      end
    endcase
    ready_d = (state_d != WAIT_MEM);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      addr_q      <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      funct3_q    <= '0;
      data_q      <= '0;
      out_rd_q    <= '0;
      we_q        <= 1'b0;
      fault_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      funct3_q    <= funct3_d;
      data_q      <= data_d;
      out_rd_q    <= out_rd_d;
      we_q        <= we_d;
      fault_q     <= fault_d;
      mis_q       <= mis_d;
    end
  end

  assign o_ready          = ready_q;
  assign o_data           = data_q;
  assign o_rd             = out_rd_q;
  assign o_reg_write      = we_q;
  assign o_fault          = fault_q;
  assign o_fault_misalign = mis_q;

endmodule
